// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock divider with duty-cycle control and a period-start strobe.
// New divisor/high-time settings are staged in shadow registers and applied only at a period boundary.
module prog_clock_divider #(
    parameter int WIDTH        = 8,
    parameter int DEFAULT_DIV  = 16,
    parameter int DEFAULT_HIGH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] high_in,
    output logic             out,
    output logic             tick,
    output logic [WIDTH-1:0] count,
    output logic             pending
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state;
    state_t           state_n;
    logic             running;
    logic             wrap;
    logic             apply;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] high_r;
    logic [WIDTH-1:0] sdiv;
    logic [WIDTH-1:0] shigh;
    logic [WIDTH-1:0] ld_div;
    logic [WIDTH-1:0] ld_high;
    logic [WIDTH-1:0] div_n;
    logic [WIDTH-1:0] high_n;
    logic [WIDTH-1:0] count_n;

    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
        return (d < WIDTH'(2)) ? WIDTH'(2) : d;
    endfunction

    function automatic logic [WIDTH-1:0] clamp_high(input logic [WIDTH-1:0] h,
                                                    input logic [WIDTH-1:0] d);
        return (h > d) ? d : h;
    endfunction

    // Any non-running edge, or the last cycle of a period, is a safe point to swap settings.
    always_comb begin
        ld_div  = clamp_div(div_in);
        ld_high = clamp_high(high_in, ld_div);
        running = (state == RUN);
        wrap    = running && (count == div_r - WIDTH'(1));
        apply   = !en || !running || wrap;

        div_n  = div_r;
        high_n = high_r;
        if (apply) begin
            if (load) begin
                div_n  = ld_div;
                high_n = ld_high;
            end else if (pending) begin
                div_n  = sdiv;
                high_n = shigh;
            end
        end

        count_n = (en && running && !wrap) ? count + WIDTH'(1) : '0;
        state_n = en ? RUN : IDLE;
    end

    // out/tick are registered from next-cycle values so they never decode glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            out     <= 1'b0;
            tick    <= 1'b0;
            pending <= 1'b0;
            div_r   <= WIDTH'(DEFAULT_DIV);
            high_r  <= WIDTH'(DEFAULT_HIGH);
            sdiv    <= WIDTH'(DEFAULT_DIV);
            shigh   <= WIDTH'(DEFAULT_HIGH);
        end else begin
            state  <= state_n;
            count  <= count_n;
            div_r  <= div_n;
            high_r <= high_n;
            out    <= en && (count_n < high_n);
            tick   <= en && (count_n == '0);
            if (load) begin
                sdiv  <= ld_div;
                shigh <= ld_high;
            end
            if (apply)
                pending <= 1'b0;
            else if (load)
                pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench for prog_clock_divider: directed test-plan steps plus random
// stimulus, all compared against a period/phase reference model.
module tb_prog_clock_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       load;
    logic [7:0] div_in;
    logic [7:0] high_in;
    logic       out;
    logic       tick;
    logic [7:0] count;
    logic       pending;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: active/shadow settings, pending flag, running flag, phase in period.
    int m_div, m_high, m_sdiv, m_shigh, m_phase;
    bit m_pend, m_run;

    prog_clock_divider #(.WIDTH(8), .DEFAULT_DIV(16), .DEFAULT_HIGH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .div_in(div_in), .high_in(high_in),
        .out(out), .tick(tick), .count(count), .pending(pending)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_div = 16; m_high = 8; m_sdiv = 16; m_shigh = 8;
        m_phase = 0; m_pend = 0; m_run = 0;
    endtask

    // Applies the rules for one rising edge using the inputs present at that edge.
    task automatic model_edge();
        int  d, h;
        bit  boundary;
        d = (int'(div_in) < 2) ? 2 : int'(div_in);
        h = (int'(high_in) > d) ? d : int'(high_in);
        boundary = !en || !m_run || (m_phase == m_div - 1);
        if (!en) begin
            m_run = 0; m_phase = 0;
        end else if (!m_run) begin
            m_run = 1; m_phase = 0;
        end else begin
            m_phase = (m_phase + 1) % m_div;
        end
        if (boundary) begin
            if (load) begin
                m_div = d; m_high = h;
            end else if (m_pend) begin
                m_div = m_sdiv; m_high = m_shigh;
            end
            m_pend = 0;
        end else if (load) begin
            m_sdiv = d; m_shigh = h; m_pend = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("count",   count,   m_phase);
        chk("out",     out,     (m_run && m_phase < m_high) ? 1 : 0);
        chk("tick",    tick,    (m_run && m_phase == 0) ? 1 : 0);
        chk("pending", pending, m_pend);
    endtask

    initial begin
        int bc[5] = '{0, 1, 2, 3, 0};
        int bo[5] = '{1, 1, 0, 0, 1};
        int bt[5] = '{1, 0, 0, 0, 1};
        int last, highs;

        rst = 1'b1; en = 1'b0; load = 1'b0; div_in = '0; high_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", count, 0);
        chk("reset_out", out, 0);
        chk("reset_tick", tick, 0);
        chk("reset_pending", pending, 0);
        rst = 1'b0;

        // Basic waveform: load 4/2 while idle, then run.
        load = 1'b1; div_in = 8'd4; high_in = 8'd2;
        step();
        chk("idle_load_pending", pending, 0);
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("basic_count", count, bc[i]);
            chk("basic_out", out, bo[i]);
            chk("basic_tick", tick, bt[i]);
        end

        // Mid-period load at count = 1.
        step();
        chk("mid_pre_count", count, 1);
        load = 1'b1; div_in = 8'd6; high_in = 8'd1;
        step();
        chk("mid_pending1", pending, 1);
        load = 1'b0;
        step();
        chk("mid_count3", count, 3);
        chk("mid_pending2", pending, 1);
        step();
        chk("mid_wrap_count", count, 0);
        chk("mid_wrap_tick", tick, 1);
        chk("mid_wrap_out", out, 1);
        chk("mid_wrap_pending", pending, 0);
        for (int i = 1; i < 6; i++) begin
            step();
            chk("mid_count", count, i);
            chk("mid_out_low", out, 0);
        end
        step();
        chk("mid_period6_tick", tick, 1);

        // Clamping: div 0 -> 2, high 9 -> 2.
        load = 1'b1; div_in = 8'd0; high_in = 8'd9;
        step();
        load = 1'b0;
        for (int i = 0; i < 10; i++) step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("clamp_out_high", out, 1);
            chk("clamp_count_lt2", (count < 8'd2), 1);
        end
        load = 1'b1; div_in = 8'd5; high_in = 8'd0;
        step();
        load = 1'b0;
        for (int i = 0; i < 6; i++) step();
        last = -1;
        for (int i = 0; i < 15; i++) begin
            step();
            chk("high0_out_low", out, 0);
            if (tick) begin
                if (last >= 0) chk("high0_tick_spacing", i - last, 5);
                last = i;
            end
        end

        // Load landing exactly on the wrap edge.
        load = 1'b1; div_in = 8'd4; high_in = 8'd2;
        step();
        load = 1'b0;
        for (int i = 0; i < 10; i++) step();
        for (int k = 0; k < 10 && count != 8'd3; k++) step();
        chk("wrap_sync", count, 3);
        load = 1'b1; div_in = 8'd3; high_in = 8'd1;
        step();
        chk("wrap_count0", count, 0);
        chk("wrap_tick", tick, 1);
        chk("wrap_out", out, 1);
        chk("wrap_pending", pending, 0);
        load = 1'b0;
        step();
        chk("wrap_out1", out, 0);
        chk("wrap_pend1", pending, 0);
        step();
        chk("wrap_out2", out, 0);
        chk("wrap_pend2", pending, 0);
        step();
        chk("wrap_period3_tick", tick, 1);

        // Enable drop at count = 2, restart, then asynchronous reset with pending set.
        for (int k = 0; k < 10 && count != 8'd2; k++) step();
        chk("en_sync", count, 2);
        en = 1'b0;
        step();
        chk("drop_count", count, 0);
        chk("drop_out", out, 0);
        chk("drop_tick", tick, 0);
        en = 1'b1;
        step();
        chk("restart_count", count, 0);
        chk("restart_tick", tick, 1);
        load = 1'b1; div_in = 8'd9; high_in = 8'd3;
        step();
        chk("prereset_pending", pending, 1);
        load = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("async_count", count, 0);
        chk("async_out", out, 0);
        chk("async_tick", tick, 0);
        chk("async_pending", pending, 0);
        model_reset();
        #1 rst = 1'b0;
        highs = 0;
        for (int i = 0; i < 17; i++) begin
            step();
            if (i < 16 && out) highs++;
            if (i == 0 || i == 16) chk("default_tick", tick, 1);
        end
        chk("default_high_cycles", highs, 8);

        // Random stimulus against the model.
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 11) != 0);
            load = ($urandom_range(0, 6) == 0);
            div_in  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            high_in = 8'($urandom_range(0, 14));
            step();
        end
        en = 1'b0; load = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
